// File: rtl/mult2_seq_ctrl.sv
// mult2_seq_ctrl: WIDTH x WIDTH unsigned multiplier sequencer that time-shares
// one external 2x2 combinational multiplier. Operands are split into 2-bit
// digits; every digit pair (i, j) is multiplied in turn, shifted by 2*(i+j)
// and accumulated into a 2*WIDTH-bit sum. One pair is processed per cycle.
//
// Handshake: a request is accepted on a rising edge where start & ready.
// ready is high only in IDLE. done pulses for exactly one cycle when product
// becomes final. start is ignored while busy or done are high.
module mult2_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [1:0]           mul_x,
    output logic [1:0]           mul_y,
    input  logic [3:0]           mul_p
);

    localparam int D  = WIDTH / 2;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [2*WIDTH-1:0]   acc;
    logic [IW-1:0]        i_idx;
    logic [IW-1:0]        j_idx;

    logic [WIDTH-1:0]     a_shift;
    logic [WIDTH-1:0]     b_shift;
    logic [IW:0]          dig_sum;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 last_pair;

    // Select the current digits for the shared multiplier and form the
    // shifted partial product; digits are only driven while running.
    always_comb begin
        a_shift   = a_reg >> {i_idx, 1'b0};
        b_shift   = b_reg >> {j_idx, 1'b0};
        mul_x     = 2'd0;
        mul_y     = 2'd0;
        if (state == S_RUN) begin
            mul_x = a_shift[1:0];
            mul_y = b_shift[1:0];
        end
        dig_sum   = {1'b0, i_idx} + {1'b0, j_idx};
        partial   = (2*WIDTH)'(mul_p) << {dig_sum, 1'b0};
        acc_sum   = acc + partial;
        last_pair = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);
    end

    // Sequencer FSM with registered handshake outputs and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            i_idx   <= '0;
            j_idx   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        i_idx <= '0;
                        j_idx <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc <= acc_sum;
                    if (last_pair) begin
                        product <= acc_sum;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else if (j_idx == LAST_IDX) begin
                        j_idx <= '0;
                        i_idx <= i_idx + 1'b1;
                    end else begin
                        j_idx <= j_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
